// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 register file with two combinational read ports and a retire counter.
// Optional write-first read bypass is enabled by defining WB_BYPASS_EN.
module wb_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_W,
  input  logic [31:0] PC8_W,
  input  logic [31:0] AO_W,
  input  logic [31:0] DR_W,
  input  logic        RegW_W,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] retired
);

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_data;
  logic          is_load;
  logic          is_link;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] retired_q;
  logic          unused_fields;

  assign op            = instr_W[31:26];
  assign funct         = instr_W[5:0];
  assign unused_fields = ^{instr_W[25:21], instr_W[10:6]};

  // Lane selection and extension of the raw memory word
  always_comb begin
    ld_byte = DR_W[7:0];
    ld_half = AO_W[1] ? DR_W[31:16] : DR_W[15:0];
    ld_data = DR_W;
    is_load = 1'b1;
    case (AO_W[1:0])
      2'd0:    ld_byte = DR_W[7:0];
      2'd1:    ld_byte = DR_W[15:8];
      2'd2:    ld_byte = DR_W[23:16];
      default: ld_byte = DR_W[31:24];
    endcase
    case (op)
      OP_LW:   ld_data = DR_W;
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: is_load = 1'b0;
    endcase
  end

  // Destination decode and write-back source select
  always_comb begin
    is_link = (op == OP_JAL) || ((op == OP_RTYPE) && (funct == FN_JALR));
    wb_addr = instr_W[20:16];
    if (op == OP_RTYPE)
      wb_addr = instr_W[15:11];
    else if (op == OP_JAL)
      wb_addr = AW'(31);
    wb_data = AO_W;
    if (is_link)
      wb_data = PC8_W;
    else if (is_load)
      wb_data = ld_data;
    wb_we = RegW_W && (wb_addr != AW'(0));
  end

  // Storage; entry 0 is cleared on reset and never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++)
        regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      retired_q <= '0;
    else if (instr_W != '0)
      retired_q <= retired_q + DW'(1);
  end

  assign retired = retired_q;

`ifdef WB_BYPASS_EN
  assign rd1 = (wb_we && (rs_addr == wb_addr)) ? wb_data : regs[rs_addr];
  assign rd2 = (wb_we && (rt_addr == wb_addr)) ? wb_data : regs[rt_addr];
`else
  assign rd1 = regs[rs_addr];
  assign rd2 = regs[rt_addr];
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table for decode/extension plus multi-cycle sequences.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_W, PC8_W, AO_W, DR_W;
  logic        RegW_W;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rd1, rd2, wb_data, retired;
  logic        wb_we;
  logic [4:0]  wb_addr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [32];
  logic [31:0] n_ret;
  logic [31:0] expv;

  wb_regfile dut (
    .clk(clk), .reset(reset), .instr_W(instr_W), .PC8_W(PC8_W), .AO_W(AO_W),
    .DR_W(DR_W), .RegW_W(RegW_W), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd1(rd1), .rd2(rd2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] ao;
    logic [31:0] dr;
    logic        regw;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, 5'd3, 5'd4, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd2, rt, 16'h1234};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    instr_W = '0; PC8_W = '0; AO_W = '0; DR_W = '0; RegW_W = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
  endtask

  // One addu commit to rd, then read it back on port 1
  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    @(negedge clk);
    instr_W = rtype(rd, 6'b100001); AO_W = d; RegW_W = 1'b1;
    @(posedge clk);
    n_ret = n_ret + 32'd1;
    if (rd != 5'd0) mdl[rd] = d;
    #1 idle();
    rs_addr = rd;
    #1 chk("wr_readback", rd1, mdl[rd]);
  endtask

  initial begin
    n_ret = '0;
    clear_model();
    idle();
    rs_addr = 5'd0; rt_addr = 5'd0;
    reset = 1'b0;

    vecs[0]  = '{"addu_r8",   rtype(5'd8, 6'b100001),  32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 5'd8,  32'hDEADBEEF};
    vecs[1]  = '{"jal_r31",   {6'b000011, 26'h0000C00}, 32'h3008, 32'h1111, 32'h0, 1'b1, 1'b1, 5'd31, 32'h00003008};
    vecs[2]  = '{"lb_b3",     itype(6'b100000, 5'd10), 32'h0, 32'h103, 32'h80FF7F01, 1'b1, 1'b1, 5'd10, 32'hFFFFFF80};
    vecs[3]  = '{"lbu_b1",    itype(6'b100100, 5'd11), 32'h0, 32'h101, 32'h80FF7F01, 1'b1, 1'b1, 5'd11, 32'h0000007F};
    vecs[4]  = '{"lh_hi",     itype(6'b100001, 5'd12), 32'h0, 32'h102, 32'h80FF7F01, 1'b1, 1'b1, 5'd12, 32'hFFFF80FF};
    vecs[5]  = '{"lhu_lo",    itype(6'b100101, 5'd13), 32'h0, 32'h100, 32'h80FF7F01, 1'b1, 1'b1, 5'd13, 32'h00007F01};
    vecs[6]  = '{"lw",        itype(6'b100011, 5'd14), 32'h0, 32'h104, 32'h80FF7F01, 1'b1, 1'b1, 5'd14, 32'h80FF7F01};
    vecs[7]  = '{"jalr_r15",  rtype(5'd15, 6'b001001), 32'h4010, 32'h999, 32'h0, 1'b1, 1'b1, 5'd15, 32'h00004010};
    vecs[8]  = '{"r0_protect",rtype(5'd0, 6'b100001),  32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF};
    vecs[9]  = '{"regw_off",  itype(6'b001001, 5'd16), 32'h0, 32'h77, 32'h0, 1'b0, 1'b0, 5'd16, 32'h00000077};
    vecs[10] = '{"lb_b0",     itype(6'b100000, 5'd17), 32'h0, 32'h200, 32'h80FF7F01, 1'b1, 1'b1, 5'd17, 32'h00000001};
    vecs[11] = '{"lb_b2",     itype(6'b100000, 5'd18), 32'h0, 32'h202, 32'h80FF7F01, 1'b1, 1'b1, 5'd18, 32'hFFFFFFFF};
    vecs[12] = '{"lbu_b3",    itype(6'b100100, 5'd19), 32'h0, 32'h203, 32'h80FF7F01, 1'b1, 1'b1, 5'd19, 32'h00000080};
    vecs[13] = '{"lh_odd_lo", itype(6'b100001, 5'd20), 32'h0, 32'h201, 32'hABCD8123, 1'b1, 1'b1, 5'd20, 32'hFFFF8123};

    // Reset state
    #2;
    chk("rst_retired", retired, 32'h0);
    rs_addr = 5'd8;
    #1 chk("rst_rd1", rd1, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      instr_W = vecs[i].instr; PC8_W = vecs[i].pc8; AO_W = vecs[i].ao;
      DR_W = vecs[i].dr; RegW_W = vecs[i].regw;
      rs_addr = vecs[i].exp_addr; rt_addr = vecs[i].exp_addr;
      #1;
      chk({vecs[i].name, "_we"},   32'(wb_we),   32'(vecs[i].exp_we));
      chk({vecs[i].name, "_addr"}, 32'(wb_addr), 32'(vecs[i].exp_addr));
      chk({vecs[i].name, "_data"}, wb_data,      vecs[i].exp_data);
      @(posedge clk);
      if (vecs[i].instr != '0) n_ret = n_ret + 32'd1;
      if (vecs[i].exp_we) mdl[vecs[i].exp_addr] = vecs[i].exp_data;
      #1 idle();
      #1;
      chk({vecs[i].name, "_rd1"}, rd1, mdl[vecs[i].exp_addr]);
      chk({vecs[i].name, "_rd2"}, rd2, mdl[vecs[i].exp_addr]);
      chk({vecs[i].name, "_ret"}, retired, n_ret);
    end

    // Same-cycle read of the register being written
    wr(5'd9, 32'h11);
    @(negedge clk);
    instr_W = rtype(5'd9, 6'b100001); AO_W = 32'h55; RegW_W = 1'b1;
    rs_addr = 5'd9; rt_addr = 5'd9;
`ifdef WB_BYPASS_EN
    expv = 32'h55;
`else
    expv = 32'h11;
`endif
    #1;
    chk("same_cyc_rd1", rd1, expv);
    chk("same_cyc_rd2", rd2, expv);
    @(posedge clk);
    n_ret = n_ret + 32'd1; mdl[9] = 32'h55;
    #1 idle();
    #1;
    chk("after_rd1", rd1, 32'h55);
    chk("after_rd2", rd2, 32'h55);

    // Ports bypass independently
    @(negedge clk);
    instr_W = rtype(5'd9, 6'b100001); AO_W = 32'h66; RegW_W = 1'b1;
    rs_addr = 5'd9; rt_addr = 5'd8;
`ifdef WB_BYPASS_EN
    expv = 32'h66;
`else
    expv = 32'h55;
`endif
    #1;
    chk("indep_rd1", rd1, expv);
    chk("indep_rd2", rd2, mdl[8]);
    @(posedge clk);
    n_ret = n_ret + 32'd1; mdl[9] = 32'h66;
    #1 idle();

    // Bubbles leave the counter alone
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_W = '0; RegW_W = 1'b1; AO_W = 32'hBAD0BAD0;
    end
    @(posedge clk);
    #1 idle();
    chk("bubble_ret", retired, n_ret);

    // Reset mid-run discards the pending write
    wr(5'd5, 32'h1234);
    @(negedge clk);
    instr_W = rtype(5'd6, 6'b100001); AO_W = 32'h600; RegW_W = 1'b1;
    rs_addr = 5'd5; rt_addr = 5'd6;
    #1 reset = 1'b0;
`ifdef WB_BYPASS_EN
    expv = 32'h600;
`else
    expv = 32'h0;
`endif
    #1;
    chk("rst_mid_rd1", rd1, 32'h0);
    chk("rst_mid_ret", retired, 32'h0);
    chk("rst_mid_rd2", rd2, expv);
    @(posedge clk);
    clear_model(); n_ret = '0;
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1 chk("rst_r6_dropped", rd2, 32'h0);
    wr(5'd5, 32'hABCD);
    chk("post_rst_ret", retired, 32'h1);

    // Counter wrap from all-ones
    @(negedge clk);
    idle();
    force dut.retired_q = 32'hFFFFFFFF;
    #1 release dut.retired_q;
    #1 chk("wrap_pre", retired, 32'hFFFFFFFF);
    @(negedge clk);
    instr_W = rtype(5'd21, 6'b100001); AO_W = 32'h5; RegW_W = 1'b1;
    @(posedge clk);
    #1 idle();
    chk("wrap_zero", retired, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
